// File: rtl/config_pkg.sv
// Core configuration record shared by front-end blocks; EmptyCfg is a small standalone default.
package config_pkg;

  typedef struct packed {
    int unsigned IFU_FQ_DEPTH;
    int unsigned INSTR_PER_FETCH;
    int unsigned ILEN;
    int unsigned VLEN;
  } cfg_t;

  localparam cfg_t EmptyCfg = '{
    IFU_FQ_DEPTH:    32'd4,
    INSTR_PER_FETCH: 32'd4,
    ILEN:            32'd32,
    VLEN:            32'd32
  };

endpackage

// File: rtl/ifu_fetch_queue.sv
// Fetch-group FIFO between the ICache stage and decode.
// Define IFU_FETCHQ_BYPASS_EN to forward a group straight to decode when the queue is empty.
module ifu_fetch_queue #(
  parameter config_pkg::cfg_t Cfg = config_pkg::EmptyCfg
) (
  input  logic                                           clk_i,
  input  logic                                           rst_ni,
  input  logic                                           flush_i,
  input  logic                                           enq_valid_i,
  output logic                                           enq_ready_o,
  input  logic [Cfg.VLEN-1:0]                            enq_pc_i,
  input  logic [Cfg.INSTR_PER_FETCH*Cfg.ILEN-1:0]        enq_instrs_i,
  input  logic [Cfg.INSTR_PER_FETCH-1:0]                 enq_slot_valid_i,
  output logic                                           deq_valid_o,
  input  logic                                           deq_ready_i,
  output logic [Cfg.VLEN-1:0]                            deq_pc_o,
  output logic [Cfg.INSTR_PER_FETCH*Cfg.ILEN-1:0]        deq_instrs_o,
  output logic [Cfg.INSTR_PER_FETCH-1:0]                 deq_slot_valid_o,
  output logic [$clog2(Cfg.IFU_FQ_DEPTH+1)-1:0]          count_o
);

  localparam int unsigned DEPTH = Cfg.IFU_FQ_DEPTH;
  localparam int unsigned N     = Cfg.INSTR_PER_FETCH;
  localparam int unsigned ILEN  = Cfg.ILEN;
  localparam int unsigned VLEN  = Cfg.VLEN;
  localparam int unsigned PW    = $clog2(DEPTH);
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [VLEN-1:0]   pc;
    logic [N*ILEN-1:0] instrs;
    logic [N-1:0]      mask;
  } fq_entry_t;

  fq_entry_t       mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q,  count_d;

  logic            enq_ready;
  logic            deq_valid;
  logic            enq_fire;
  logic            deq_fire;
  logic            byp;
  logic            push;
  logic            pop;

`ifdef IFU_FETCHQ_BYPASS_EN
  assign byp = (count_q == '0) & enq_valid_i & (|enq_slot_valid_i) & ~flush_i;
`else
  assign byp = 1'b0;
`endif

  assign enq_ready = (count_q < CW'(DEPTH));
  assign deq_valid = ((count_q != '0) | byp) & ~flush_i;
  assign enq_fire  = enq_valid_i & enq_ready & ~flush_i;
  assign deq_fire  = deq_valid & deq_ready_i & ~flush_i;

  // Empty-mask groups complete the handshake but are dropped; a consumed bypass group is never stored.
  assign push = enq_fire & (|enq_slot_valid_i) & ~(byp & deq_ready_i);
  assign pop  = deq_fire & (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; occupancy is tracked solely by the pointers and count.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{pc: enq_pc_i, instrs: enq_instrs_i, mask: enq_slot_valid_i};
    end
  end

  assign enq_ready_o      = enq_ready;
  assign deq_valid_o      = deq_valid;
  assign deq_pc_o         = byp ? enq_pc_i         : mem_q[rd_ptr_q].pc;
  assign deq_instrs_o     = byp ? enq_instrs_i     : mem_q[rd_ptr_q].instrs;
  assign deq_slot_valid_o = byp ? enq_slot_valid_i : mem_q[rd_ptr_q].mask;
  assign count_o          = count_q;

endmodule

// File: doc/ifu_fetch_queue.md
IFU_FETCH_QUEUE -- requirements
Module: ifu_fetch_queue

Interface
REQ-001 SHALL have parameter Cfg, default config_pkg::EmptyCfg, source of all derived widths below.
REQ-002 SHALL derive DEPTH = Cfg.IFU_FQ_DEPTH (power of two, >=2), N = Cfg.INSTR_PER_FETCH, ILEN = Cfg.ILEN, VLEN = Cfg.VLEN.
REQ-003 SHALL have port clk_i  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port flush_i  in  1  redirect/flush, discard all contents.
REQ-006 SHALL have port enq_valid_i  in  1  fetch group offered by ICache stage.
REQ-007 SHALL have port enq_ready_o  out  1  queue accepts group.
REQ-008 SHALL have port enq_pc_i  in  VLEN  PC of slot 0.
REQ-009 SHALL have port enq_instrs_i  in  N*ILEN  instructions, slot i at bits [i*ILEN +: ILEN].
REQ-010 SHALL have port enq_slot_valid_i  in  N  per-slot valid mask.
REQ-011 SHALL have port deq_valid_o  out  1  group available to decode.
REQ-012 SHALL have port deq_ready_i  in  1  decode consumes group.
REQ-013 SHALL have ports deq_pc_o (VLEN), deq_instrs_o (N*ILEN), deq_slot_valid_o (N)  out  head group fields.
REQ-014 SHALL have port count_o  out  $clog2(DEPTH+1)  occupied entries.

Function
REQ-015 SHALL store groups in a DEPTH-entry circular buffer, read/write pointers log2(DEPTH) bits, wrapping DEPTH-1 -> 0.
REQ-016 Enqueue SHALL occur when enq_valid_i & enq_ready_o & !flush_i; dequeue when deq_valid_o & deq_ready_i & !flush_i.
REQ-017 enq_ready_o SHALL be 1 iff count_o < DEPTH; no same-cycle enqueue into a full queue even when dequeuing.
REQ-018 deq_valid_o SHALL be 1 iff count_o > 0 and flush_i = 0; deq_* fields SHALL reflect the head entry.
REQ-019 Enqueue-to-deq_valid_o latency SHALL be 1 cycle when empty (bypass disabled).
REQ-020 Simultaneous enqueue and dequeue SHALL leave count_o unchanged and advance both pointers.
REQ-021 Group with enq_slot_valid_i == 0 SHALL be accepted (handshake completes) but not stored.
REQ-022 flush_i SHALL set count_o and both pointers to 0 next cycle; any same-cycle enqueue/dequeue is discarded.
REQ-023 deq_* data SHALL remain stable while deq_valid_o & !deq_ready_i.
REQ-024 count_o SHALL equal enqueues minus dequeues since last reset/flush, never exceeding DEPTH.

Reset
REQ-025 On rst_ni low, pointers and count_o SHALL be 0, deq_valid_o 0, enq_ready_o 1 (combinational, may follow after deassert), asynchronously.
REQ-026 Reset asserted mid-transfer SHALL drop all stored groups; no entry survives reset.
REQ-027 Storage array contents need not be reset; deq_* data is don't-care when deq_valid_o = 0.

Configuration
REQ-028 With macro IFU_FETCHQ_BYPASS_EN defined: when count_o = 0, enq_valid_i = 1, nonzero slot mask, flush_i = 0, deq_valid_o SHALL be 1 combinationally with deq_* = enq_*; if deq_ready_i = 1 the group SHALL NOT be stored (count stays 0), else stored normally.
REQ-029 Without IFU_FETCHQ_BYPASS_EN: no combinational enq->deq path; REQ-019 latency applies.

Verification
REQ-030 Reset, then enqueue PC 0x8000_0000 mask 4'b1111 -> next cycle deq_valid_o=1, deq_pc_o=0x8000_0000, count_o=1 (bypass off).
REQ-031 DEPTH=4, deq_ready_i=0, enqueue 5 groups -> enq_ready_o=0 after 4th, count_o=4, 5th held; release deq_ready_i -> PCs out in order.
REQ-032 count_o=2, enq and deq same cycle for 3 cycles -> count_o stays 2, pointers wrap past 3 to 0 correctly.
REQ-033 count_o=3, assert flush_i with enq_valid_i=1 -> next cycle count_o=0, deq_valid_o=0, flushed-cycle group absent.
REQ-034 Enqueue mask 4'b0000 -> enq_ready_o=1, count_o unchanged at 0.
REQ-035 IFU_FETCHQ_BYPASS_EN defined, empty, deq_ready_i=1, enqueue PC 0x100 -> same-cycle deq_valid_o=1, deq_pc_o=0x100, next count_o=0.
